// File: rtl/core_pkg.sv
// Purpose : shared types and constants for the immediate-generation stage.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: imm_fmt_e immediate format enum, skid-buffer state enum,
//           RISC-V major opcodes used by the format decoder, width constants.
package core_pkg;

  localparam int ILEN_W   = 32;
  localparam int XLEN_DEF = 32;
  localparam int FMT_W    = 3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_extract.sv
// Purpose : classify the immediate format of one instruction and extend it to XLEN.
// Latency : purely combinational.
// Backpressure: none; no handshake on this block.
// Ports   : insn_i (32b instruction) -> fmt_o (imm_fmt_e), imm_o (XLEN-wide immediate).
module imm_extract
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      insn_i,
  output logic [FMT_W-1:0] fmt_o,
  output logic [XLEN-1:0]  imm_o
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  imm_fmt_e           fmt;
  logic signed [11:0] imm_i12;
  logic signed [11:0] imm_s12;
  logic signed [12:0] imm_b13;
  logic signed [31:0] imm_u32;
  logic signed [20:0] imm_j21;

  assign opcode  = insn_i[6:0];
  assign funct3  = insn_i[14:12];

  assign imm_i12 = insn_i[31:20];
  assign imm_s12 = {insn_i[31:25], insn_i[11:7]};
  assign imm_b13 = {insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
  assign imm_u32 = {insn_i[31:12], 12'b0};
  assign imm_j21 = {insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};

  always_comb begin
    fmt = FMT_NONE;
    unique case (opcode)
      // slli/srli/srai (funct3 001/101) carry a shift amount, not a signed immediate
      OPC_OP_IMM:          fmt = (funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
      OPC_LOAD, OPC_JALR:  fmt = FMT_I;
      OPC_STORE:           fmt = FMT_S;
      OPC_BRANCH:          fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:  fmt = FMT_U;
      OPC_JAL:             fmt = FMT_J;
      // only the CSR*I forms (funct3[2]=1) have a 5-bit zero-extended operand
      OPC_SYSTEM:          fmt = funct3[2] ? FMT_ZIMM : FMT_NONE;
      default:             fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    unique case (fmt)
      FMT_I:     imm_o = XLEN'(imm_i12);
      FMT_S:     imm_o = XLEN'(imm_s12);
      FMT_B:     imm_o = XLEN'(imm_b13);
      FMT_U:     imm_o = XLEN'(imm_u32);
      FMT_J:     imm_o = XLEN'(imm_j21);
      // RV64 shifts use a 6-bit shamt; RV32 only 5 bits (bit 25 belongs to funct7)
      FMT_SHAMT: imm_o = (XLEN == 64) ? XLEN'(insn_i[25:20]) : XLEN'(insn_i[24:20]);
      FMT_ZIMM:  imm_o = XLEN'(insn_i[19:15]);
      default:   imm_o = '0;
    endcase
  end

  assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_stage.sv
// Purpose : pipelined immediate generator between fetch and register-read/execute.
// Latency : one cycle from acceptance to valid_o when the buffer is empty.
// Backpressure: 2-entry skid buffer; ready_o drops only when both entries are full,
//           and depends on state flops only (no path from ready_i).
// Ports   : clk/reset (sync, active-high), flush_i; valid_i/ready_o/insn_i in;
//           valid_o/ready_i/insn_o/imm_o/fmt_o out, all outputs from flops.
module imm_gen_stage
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [ILEN-1:0]  insn_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [ILEN-1:0]  insn_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [FMT_W-1:0] fmt_o
);

  // Entry computed on the input side; it is the next-state value for
  // whichever buffer slot the new instruction lands in.
  logic [FMT_W-1:0] ent_fmt_d;
  logic [XLEN-1:0]  ent_imm_d;

  skid_state_e      state_q;
  logic [ILEN-1:0]  head_insn_q;
  logic [XLEN-1:0]  head_imm_q;
  logic [FMT_W-1:0] head_fmt_q;
  logic [ILEN-1:0]  skid_insn_q;
  logic [XLEN-1:0]  skid_imm_q;
  logic [FMT_W-1:0] skid_fmt_q;

  logic acc;
  logic con;

  imm_extract #(
    .XLEN (XLEN)
  ) u_imm_extract (
    .insn_i (insn_i),
    .fmt_o  (ent_fmt_d),
    .imm_o  (ent_imm_d)
  );

  assign ready_o = (state_q != ST_TWO);
  assign valid_o = (state_q != ST_EMPTY);
  assign acc     = valid_i & ready_o & ~flush_i;
  assign con     = valid_o & ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_insn_q <= '0;
      head_imm_q  <= '0;
      head_fmt_q  <= FMT_NONE;
      skid_insn_q <= '0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= FMT_NONE;
    end else if (flush_i) begin
      // Data flops keep stale contents; valid_o masks them.
      state_q <= ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            head_insn_q <= insn_i;
            head_imm_q  <= ent_imm_d;
            head_fmt_q  <= ent_fmt_d;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && con) begin
            // head leaves and the new entry takes its place in the same cycle
            head_insn_q <= insn_i;
            head_imm_q  <= ent_imm_d;
            head_fmt_q  <= ent_fmt_d;
          end else if (acc) begin
            skid_insn_q <= insn_i;
            skid_imm_q  <= ent_imm_d;
            skid_fmt_q  <= ent_fmt_d;
            state_q     <= ST_TWO;
          end else if (con) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // ready_o is low here, so only a consume can happen
          if (con) begin
            head_insn_q <= skid_insn_q;
            head_imm_q  <= skid_imm_q;
            head_fmt_q  <= skid_fmt_q;
            state_q     <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign insn_o = head_insn_q;
  assign imm_o  = head_imm_q;
  assign fmt_o  = head_fmt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Purpose : self-checking bench for imm_gen_stage at XLEN=32 and XLEN=64 in parallel.
// Latency : n/a.
// Backpressure: exercised with held/toggled ready_i and flush_i.
module tb_imm_gen_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] insn_i;

  logic        rdy32, vld32, rdy64, vld64;
  logic [31:0] insn32, insn64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected contents of the stage, oldest first.
  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .ILEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy32),
    .insn_i(insn_i), .valid_o(vld32), .ready_i(ready_i), .insn_o(insn32),
    .imm_o(imm32), .fmt_o(fmt32)
  );

  imm_gen_stage #(.XLEN(64), .ILEN(32)) dut64 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy64),
    .insn_i(insn_i), .valid_o(vld64), .ready_i(ready_i), .insn_o(insn64),
    .imm_o(imm64), .fmt_o(fmt64)
  );

  function automatic logic [2:0] ref_fmt(input logic [31:0] insn);
    logic [6:0] op;
    logic [2:0] f3;
    op = insn[6:0];
    f3 = insn[14:12];
    if (op == 7'b0010011) return (f3 == 3'b001 || f3 == 3'b101) ? 3'd6 : 3'd1;
    if (op == 7'b0000011 || op == 7'b1100111) return 3'd1;
    if (op == 7'b0100011) return 3'd2;
    if (op == 7'b1100011) return 3'd3;
    if (op == 7'b0110111 || op == 7'b0010111) return 3'd4;
    if (op == 7'b1101111) return 3'd5;
    if (op == 7'b1110011 && f3[2]) return 3'd7;
    return 3'd0;
  endfunction

  // Immediate value as a two's-complement integer, reduced to xlen bits.
  function automatic logic [63:0] ref_imm(input logic [31:0] insn, input int xlen);
    logic [63:0] v;
    v = 64'd0;
    case (ref_fmt(insn))
      3'd1: v = 64'(insn[31:20]) - (insn[31] ? 64'd4096 : 64'd0);
      3'd2: v = 64'(insn[31:25]) * 32 + 64'(insn[11:7]) - (insn[31] ? 64'd4096 : 64'd0);
      3'd3: v = 64'(insn[7]) * 2048 + 64'(insn[30:25]) * 32 + 64'(insn[11:8]) * 2
                - (insn[31] ? 64'd4096 : 64'd0);
      3'd4: v = 64'(insn[30:12]) * 4096 - (insn[31] ? 64'h8000_0000 : 64'd0);
      3'd5: v = 64'(insn[19:12]) * 4096 + 64'(insn[20]) * 2048 + 64'(insn[30:21]) * 2
                - (insn[31] ? 64'h10_0000 : 64'd0);
      3'd6: v = (xlen == 32) ? 64'(insn[24:20]) : 64'(insn[25:20]);
      3'd7: v = 64'(insn[19:15]);
      default: v = 64'd0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input bit after_reset);
    logic [63:0] e32, e64;
    chk("ready32", 64'(rdy32), 64'(q.size() < 2));
    chk("ready64", 64'(rdy64), 64'(q.size() < 2));
    chk("valid32", 64'(vld32), 64'(q.size() > 0));
    chk("valid64", 64'(vld64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      e32 = ref_imm(q[0], 32);
      e64 = ref_imm(q[0], 64);
      chk("head_insn32", 64'(insn32), 64'(q[0]));
      chk("head_insn64", 64'(insn64), 64'(q[0]));
      chk("head_imm32",  64'(imm32),  e32);
      chk("head_imm64",  imm64,       e64);
      chk("head_fmt32",  64'(fmt32),  64'(ref_fmt(q[0])));
      chk("head_fmt64",  64'(fmt64),  64'(ref_fmt(q[0])));
    end
    if (after_reset) begin
      chk("rst_insn32", 64'(insn32), 64'd0);
      chk("rst_imm32",  64'(imm32),  64'd0);
      chk("rst_imm64",  imm64,       64'd0);
      chk("rst_fmt32",  64'(fmt32),  64'(FMT_NONE));
      chk("rst_fmt64",  64'(fmt64),  64'(FMT_NONE));
    end
  endtask

  // One clock: predict transfers from the model, advance the model at the
  // edge, then check the DUT outputs 1ns later.
  task automatic cyc();
    bit acc, con, rst;
    acc = valid_i && (q.size() < 2) && !flush_i;
    con = (q.size() > 0) && ready_i;
    @(posedge clk);
    rst = reset;
    if (rst || flush_i) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(insn_i);
    end
    #1;
    model_check(rst);
  endtask

  task automatic send(input string tag, input logic [31:0] insn, input logic [31:0] e32,
                      input logic [63:0] e64, input logic [2:0] efmt);
    valid_i = 1'b1;
    ready_i = 1'b1;
    insn_i  = insn;
    cyc();
    valid_i = 1'b0;
    chk({tag, "_valid"}, 64'(vld32), 64'd1);
    chk({tag, "_imm32"}, 64'(imm32), 64'(e32));
    chk({tag, "_imm64"}, imm64, e64);
    chk({tag, "_fmt"},   64'(fmt32), 64'(efmt));
    cyc();
  endtask

  localparam logic [31:0] INS_A = 32'hFFF0_0093;  // addi x1,x0,-1
  localparam logic [31:0] INS_B = 32'h0081_2223;  // sw
  localparam logic [31:0] INS_C = 32'h0040_006F;  // jal
  localparam logic [31:0] INS_D = 32'h8000_00B7;  // lui

  logic [6:0]  ops [10] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110111,
                            7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011, 7'b0110011};
  logic [31:0] r;
  int          sel;

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    insn_i  = '0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("ready_after_reset", 64'(rdy32), 64'd1);

    // Directed format/immediate checks.
    send("addi",   32'hFFF0_0093, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I);
    send("beq",    32'hFE00_0EE3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B);
    send("srai",   32'h4030_D093, 32'h0000_0003, 64'h0000_0000_0000_0003, FMT_SHAMT);
    send("csrrwi", 32'h3002_D073, 32'h0000_0005, 64'h0000_0000_0000_0005, FMT_ZIMM);
    send("lui",    32'h8000_00B7, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, FMT_U);
    send("add",    32'h0020_81B3, 32'h0000_0000, 64'h0000_0000_0000_0000, FMT_NONE);

    // Back-pressure: A and B fill the buffer, C is held.
    ready_i = 1'b0;
    valid_i = 1'b1;
    insn_i  = INS_A;
    cyc();
    insn_i = INS_B;
    cyc();
    chk("bp_full_ready", 64'(rdy32), 64'd0);
    insn_i = INS_C;
    repeat (3) begin
      cyc();
      chk("bp_hold_insn", 64'(insn32), 64'(INS_A));
      chk("bp_hold_imm",  64'(imm32),  64'hFFFF_FFFF);
    end
    ready_i = 1'b1;
    cyc();
    chk("bp_out_B", 64'(insn32), 64'(INS_B));
    cyc();
    chk("bp_out_C", 64'(insn32), 64'(INS_C));
    valid_i = 1'b0;
    cyc();
    chk("bp_drained", 64'(vld32), 64'd0);

    // Flush from TWO with a simultaneous offer and consume.
    ready_i = 1'b0;
    valid_i = 1'b1;
    insn_i  = INS_A;
    cyc();
    insn_i = INS_B;
    cyc();
    flush_i = 1'b1;
    ready_i = 1'b1;
    insn_i  = INS_D;
    cyc();
    chk("flush_valid", 64'(vld64), 64'd0);
    chk("flush_ready", 64'(rdy64), 64'd1);
    flush_i = 1'b0;
    valid_i = 1'b0;
    repeat (3) begin
      cyc();
      chk("flush_no_output", 64'(vld32), 64'd0);
    end

    // Reset while holding one entry.
    ready_i = 1'b0;
    valid_i = 1'b1;
    insn_i  = INS_D;
    cyc();
    chk("one_before_reset", 64'(vld32), 64'd1);
    valid_i = 1'b0;
    reset   = 1'b1;
    cyc();
    chk("reset_valid", 64'(vld32), 64'd0);
    chk("reset_imm64", imm64, 64'd0);
    reset = 1'b0;
    cyc();
    chk("reset_ready", 64'(rdy32), 64'd1);

    // Random traffic against the queue model.
    repeat (500) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 19) == 0);
      r   = $urandom();
      sel = $urandom_range(0, 10);
      insn_i = (sel == 10) ? r : {r[31:7], ops[sel]};
      cyc();
    end
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
